// File: rtl/cpu_pkg.sv
// Shared opcode, FSM state and ALU code definitions
// for the cpu_sequencer control unit.
package cpu_pkg;

  localparam int unsigned OP_LOAD = 0;
  localparam int unsigned OP_MOVE = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_XOR  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MOVE = 3'd2,
    S_ALU1 = 3'd3,
    S_ALU2 = 3'd4,
    S_ALU3 = 3'd5,
    S_ILL  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_XOR = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

  function automatic logic is_alu(
    input int unsigned op
  );
    return (op >= OP_ADD) && (op <= OP_AND);
  endfunction

  function automatic state_e issue_state(
    input int unsigned op,
    input logic        alu_en
  );
    if (op == OP_LOAD) return S_LOAD;
    if (op == OP_MOVE) return S_MOVE;
    if (alu_en && is_alu(op)) return S_ALU1;
    return S_ILL;
  endfunction

  function automatic alu_op_e alu_code(
    input int unsigned op
  );
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable;
// all-zero output while disabled.
module onehot_dec #(
  parameter int ARG_SIZE = 3
) (
  input  logic [ARG_SIZE-1:0]      idx_i,
  input  logic                     en_i,
  output logic [2**ARG_SIZE-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle register-transfer sequencer: latches one
// instruction and steps the bus/ALU enables for it.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ALU_EN   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OP_SIZE+2*ARG_SIZE-1:0]   instr,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  output logic [2**ARG_SIZE-1:0]          reg_en,
  output logic [2**ARG_SIZE-1:0]          reg_tri,
  output logic                            ext_tri,
  output logic                            alu_tri,
  output logic                            alu_a_en,
  output logic                            alu_g_en,
  output logic [1:0]                      alu_op,
  output logic                            done,
  output logic                            pc_written,
  output logic                            illegal
);

  localparam int NREG = 2**ARG_SIZE;
  localparam int IW   = OP_SIZE + 2*ARG_SIZE;
  localparam logic [ARG_SIZE-1:0] PC_IDX =
    ARG_SIZE'(NREG-1);

  state_e              state_q, state_d;
  logic [IW-1:0]       instr_q, instr_d;
  logic                accept;
  logic [OP_SIZE-1:0]  op_in, op_q;
  logic [ARG_SIZE-1:0] x_q, y_q;
  logic [NREG-1:0]     x_oh, y_oh;

  logic st_load, st_move, st_ill;
  logic st_alu1, st_alu2, st_alu3;
  logic retire;

  assign op_in = instr[IW-1 -: OP_SIZE];
  assign op_q  = instr_q[IW-1 -: OP_SIZE];
  assign x_q   = instr_q[2*ARG_SIZE-1 -: ARG_SIZE];
  assign y_q   = instr_q[ARG_SIZE-1:0];

  // Ready is the only output that looks at rst directly.
  assign instr_ready = rst
                     & (state_q != S_ALU1)
                     & (state_q != S_ALU2);
  assign accept = instr_valid & instr_ready;

  always_comb begin
    state_d = S_IDLE;
    instr_d = instr_q;
    if (accept) begin
      instr_d = instr;
      state_d = issue_state(32'(op_in), ALU_EN != 0);
    end else if (state_q == S_ALU1) begin
      state_d = S_ALU2;
    end else if (state_q == S_ALU2) begin
      state_d = S_ALU3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign st_load = (state_q == S_LOAD);
  assign st_move = (state_q == S_MOVE);
  assign st_alu1 = (state_q == S_ALU1);
  assign st_alu2 = (state_q == S_ALU2);
  assign st_alu3 = (state_q == S_ALU3);
  assign st_ill  = (state_q == S_ILL);
  assign retire  = st_load | st_move | st_alu3;

  onehot_dec #(
    .ARG_SIZE (ARG_SIZE)
  ) u_dec_x (
    .idx_i    (x_q),
    .en_i     (retire | st_alu1),
    .onehot_o (x_oh)
  );

  onehot_dec #(
    .ARG_SIZE (ARG_SIZE)
  ) u_dec_y (
    .idx_i    (y_q),
    .en_i     (st_move | st_alu2),
    .onehot_o (y_oh)
  );

  always_comb begin
    reg_en   = '0;
    reg_tri  = '0;
    ext_tri  = 1'b0;
    alu_tri  = 1'b0;
    alu_a_en = 1'b0;
    alu_g_en = 1'b0;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    unique case (1'b1)
      st_load: begin
        reg_en  = x_oh;
        ext_tri = 1'b1;
      end
      st_move: begin
        reg_en  = x_oh;
        reg_tri = y_oh;
      end
      st_alu1: begin
        reg_tri  = x_oh;
        alu_a_en = 1'b1;
      end
      st_alu2: begin
        reg_tri  = y_oh;
        alu_g_en = 1'b1;
        alu_op   = alu_code(32'(op_q));
      end
      st_alu3: begin
        alu_tri = 1'b1;
        reg_en  = x_oh;
      end
      st_ill:  illegal = 1'b1;
      default: ;
    endcase
    done       = retire & (x_q != PC_IDX);
    pc_written = retire & (x_q == PC_IDX);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed
// scenarios plus a random instruction stream.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [7:0] ren;
    logic [7:0] rtri;
    logic       ext;
    logic       alu;
    logic       a;
    logic       g;
    logic [1:0] op;
    logic       done;
    logic       pcw;
    logic       ill;
    logic       rdy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] reg_en, reg_tri;
  logic       ext_tri, alu_tri;
  logic       alu_a_en, alu_g_en;
  logic [1:0] alu_op;
  logic       done, pc_written, illegal;

  int tests = 0;
  int fails = 0;

  obs_t exp_q[$];
  obs_t future[$];

  // ALU code by opcode: ADD=2, XOR=3, SUB=4, AND=5
  logic [1:0] code_tbl [6] =
    '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};

  cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_en      (reg_en),
    .reg_tri     (reg_tri),
    .ext_tri     (ext_tri),
    .alu_tri     (alu_tri),
    .alu_a_en    (alu_a_en),
    .alu_g_en    (alu_g_en),
    .alu_op      (alu_op),
    .done        (done),
    .pc_written  (pc_written),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s.ren  = reg_en;
    s.rtri = reg_tri;
    s.ext  = ext_tri;
    s.alu  = alu_tri;
    s.a    = alu_a_en;
    s.g    = alu_g_en;
    s.op   = alu_op;
    s.done = done;
    s.pcw  = pc_written;
    s.ill  = illegal;
    s.rdy  = instr_ready;
    return s;
  endfunction

  function automatic bit inv_ok(input obs_t s);
    int drv;
    drv = int'(s.rtri != 0) + int'(s.ext) + int'(s.alu);
    return (drv <= 1)
        && ($countones(s.rtri) <= 1)
        && ($countones(s.ren) <= 1)
        && !(s.done && s.pcw);
  endfunction

  // Model: expected outputs for the cycle after the coming edge.
  task automatic drive_now(input logic v, input logic [9:0] ins);
    obs_t e, c2, c3;
    logic [3:0] op;
    logic [2:0] x, y;
    instr_valid = v;
    instr = ins;
    op = ins[9:6];
    x  = ins[5:3];
    y  = ins[2:0];
    e = '0;
    if (future.size() != 0) begin
      e = future.pop_front();
    end else if (v) begin
      if (op == 4'd0) begin
        e.ren  = 8'b1 << x;
        e.ext  = 1'b1;
        e.done = (x != 3'd7);
        e.pcw  = (x == 3'd7);
      end else if (op == 4'd1) begin
        e.ren  = 8'b1 << x;
        e.rtri = 8'b1 << y;
        e.done = (x != 3'd7);
        e.pcw  = (x == 3'd7);
      end else if (op <= 4'd5) begin
        e.rtri  = 8'b1 << x;
        e.a     = 1'b1;
        c2      = '0;
        c2.rtri = 8'b1 << y;
        c2.g    = 1'b1;
        c2.op   = code_tbl[op];
        c3      = '0;
        c3.alu  = 1'b1;
        c3.ren  = 8'b1 << x;
        c3.done = (x != 3'd7);
        c3.pcw  = (x == 3'd7);
        future.push_back(c2);
        future.push_back(c3);
      end else begin
        e.ill = 1'b1;
      end
    end
    e.rdy = (future.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic v, input logic [9:0] ins);
    @(negedge clk);
    drive_now(v, ins);
  endtask

  task automatic check_zero(input string name);
    obs_t g;
    g = sample();
    tests++;
    if (g !== '0) begin
      fails++;
      $display("FAIL %s: got %h expected 0", name, g);
    end
  endtask

  initial begin : monitor
    obs_t me, mg;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() != 0) begin
        me = exp_q.pop_front();
        mg = sample();
        tests++;
        if (mg !== me) begin
          fails++;
          $display("FAIL outputs @%0t: got %h expected %h",
                   $time, mg, me);
        end
        tests++;
        if (!inv_ok(mg)) begin
          fails++;
          $display("FAIL bus_exclusive @%0t: got %h",
                   $time, mg);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] rop;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_outputs");

    @(negedge clk);
    rst = 1'b1;
    drive_now(1'b1, {4'd0, 3'd2, 3'd0});
    cycle(1'b1, {4'd4, 3'd1, 3'd3});
    cycle(1'b1, 10'($urandom));
    cycle(1'b1, 10'($urandom));
    cycle(1'b1, {4'd1, 3'd7, 3'd0});
    cycle(1'b1, {4'hF, 6'($urandom)});
    cycle(1'b1, {4'd2, 3'd3, 3'd4});
    cycle(1'b1, 10'($urandom));
    cycle(1'b1, 10'($urandom));
    cycle(1'b1, {4'd3, 3'd5, 3'd6});
    cycle(1'b1, 10'($urandom));
    cycle(1'b1, 10'($urandom));
    cycle(1'b0, '0);

    cycle(1'b1, {4'd2, 3'd1, 3'd2});
    cycle(1'b0, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("reset_async");
    future.delete();
    @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    drive_now(1'b1, {4'd0, 3'd5, 3'd0});

    repeat (400) begin
      if ($urandom_range(0, 9) == 0)
        rop = 4'($urandom_range(6, 15));
      else
        rop = 4'($urandom_range(0, 5));
      cycle($urandom_range(0, 3) != 0,
            {rop, 6'($urandom)});
    end

    repeat (4) cycle(1'b0, '0);
    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OP_SIZE, default 4, opcode field width.
REQ-002 SHALL have parameter ARG_SIZE, default 3, register-index field width; NREG = 2**ARG_SIZE, and index NREG-1 is PC.
REQ-003 SHALL have parameter ALU_EN, default 1; when 0, the ALU opcodes decode as illegal.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 instr  in  OP_SIZE+2*ARG_SIZE  instruction = {op, arg1 (dest X), arg2 (source Y)}.
REQ-007 instr_valid  in  1  instr is presented.
REQ-008 instr_ready  out  1  sequencer accepts instr this cycle.
REQ-009 reg_en  out  NREG  one-hot register load from bus.
REQ-010 reg_tri  out  NREG  one-hot register drive onto bus.
REQ-011 ext_tri  out  1  external data drives bus.
REQ-012 alu_tri  out  1  ALU result G drives bus.
REQ-013 alu_a_en, alu_g_en  out  1 each  latch operand A; latch result G.
REQ-014 alu_op  out  2  00 ADD, 01 SUB, 10 XOR, 11 AND; valid while alu_g_en=1, else 00.
REQ-015 done  out  1  one-cycle pulse: instruction retired, PC increments.
REQ-016 pc_written  out  1  one-cycle pulse: instruction retired with dest PC (replaces done).
REQ-017 illegal  out  1  one-cycle pulse: unknown opcode accepted and discarded.

Function
REQ-018 Opcodes SHALL be LOAD=0, MOVE=1, ADD=2, XOR=3, SUB=4, AND=5; all others illegal.
REQ-019 States SHALL be IDLE, LOAD, MOVE, ALU1, ALU2, ALU3, ILL.
REQ-020 Accept = instr_valid & instr_ready; on accept, instr SHALL be latched into an internal register; outputs use only the latched copy, so instr changes mid-operation have no effect.
REQ-021 instr_ready SHALL be 1 in IDLE, LOAD, MOVE, ALU3 and ILL, 0 in ALU1/ALU2, and 0 while rst is low.
REQ-022 On accept the next state SHALL be LOAD/MOVE/ALU1/ILL by opcode; with no accept, terminal states (LOAD, MOVE, ALU3, ILL) SHALL go to IDLE.
REQ-023 ALU1 SHALL go to ALU2, and ALU2 SHALL go to ALU3, unconditionally.
REQ-024 LOAD: reg_en[arg1]=1, ext_tri=1, retire.
REQ-025 MOVE: reg_en[arg1]=1, reg_tri[arg2]=1, retire.
REQ-026 ALU1: reg_tri[arg1]=1, alu_a_en=1.
REQ-027 ALU2: reg_tri[arg2]=1, alu_g_en=1, alu_op per opcode.
REQ-028 ALU3: alu_tri=1, reg_en[arg1]=1, retire.
REQ-029 Retire SHALL assert done=1 if arg1 != NREG-1, else pc_written=1; never both.
REQ-030 ILL: illegal=1 and all other outputs 0.
REQ-031 Latency from accept edge: LOAD/MOVE retire in the next cycle; ALU ops retire in the third cycle; back-to-back issue SHALL have no bubble.
REQ-032 At most one of reg_tri, ext_tri and alu_tri SHALL be nonzero in any cycle, and reg_tri/reg_en SHALL have popcount <= 1.
REQ-033 MOVE with arg1 = arg2 SHALL be legal, driving the same index on reg_en and reg_tri.
REQ-034 All outputs SHALL be Moore (decoded from state and the latched instruction) except instr_ready.

Reset
REQ-035 rst low SHALL immediately force state IDLE, clear the latched instr to 0, and drive every output to 0.
REQ-036 Reset mid-ALU-sequence SHALL abandon the instruction with no retire pulse; the first accept occurs at the first rising edge after rst rises.

Structure
REQ-037 Package cpu_pkg SHALL hold the opcode constants, the state encoding and the alu_op codes.
REQ-038 Sub-module onehot_dec (parameter ARG_SIZE, enable input) SHALL be instantiated for the arg1 and arg2 decodes.

Verification
REQ-039 Scenario: LOAD R2 (instr=0000_010_000, valid 1 cycle) -> next cycle reg_en=00000100, ext_tri=1, done=1.
REQ-040 Scenario: SUB R1,R3 -> ALU1 reg_tri=00000010 and alu_a_en; ALU2 reg_tri=00001000, alu_g_en, alu_op=01; ALU3 alu_tri, reg_en=00000010, done; instr_ready=0 for 2 cycles.
REQ-041 Scenario: MOVE PC,R0 -> reg_en=10000000, reg_tri=00000001, pc_written=1, done=0.
REQ-042 Scenario: opcode 1111 -> illegal=1 for 1 cycle, no enables, next instruction accepted the following cycle.
REQ-043 Scenario: ADD, then XOR with instr toggling during ALU1/2 -> no bubble, alu_op=00 then 10, and toggles ignored; random stream SHALL never violate REQ-032.
REQ-044 Scenario: rst low during ALU2 -> all outputs 0 at once, no done; LOAD accepted the first edge after release.
